// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control_pkg                                                   |
// | Shared state encodings, opcode/funct values, ALU and mux select codes.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_INIT      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_R_WB      = 4'd8,
        S_EXEC_I    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_JAL       = 4'd13,
        S_JR        = 4'd14,
        S_UNUSED    = 4'd15
    } state_e;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_slti  = 6'h0a;
    localparam logic [5:0] c_op_andi  = 6'h0c;
    localparam logic [5:0] c_op_ori   = 6'h0d;
    localparam logic [5:0] c_op_xori  = 6'h0e;
    localparam logic [5:0] c_op_lui   = 6'h0f;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2b;

    localparam logic [5:0] c_fn_srl = 6'h02;
    localparam logic [5:0] c_fn_jr  = 6'h08;
    localparam logic [5:0] c_fn_add = 6'h20;
    localparam logic [5:0] c_fn_sub = 6'h22;
    localparam logic [5:0] c_fn_and = 6'h24;
    localparam logic [5:0] c_fn_or  = 6'h25;
    localparam logic [5:0] c_fn_xor = 6'h26;
    localparam logic [5:0] c_fn_slt = 6'h2a;

    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_or  = 3'b001;
    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_xor = 3'b011;
    localparam logic [2:0] c_alu_srl = 3'b101;
    localparam logic [2:0] c_alu_sub = 3'b110;
    localparam logic [2:0] c_alu_slt = 3'b111;

    localparam logic [1:0] c_dst_rt = 2'b00;
    localparam logic [1:0] c_dst_rd = 2'b01;
    localparam logic [1:0] c_dst_ra = 2'b10;

    localparam logic [1:0] c_m2r_aluout = 2'b00;
    localparam logic [1:0] c_m2r_mdr    = 2'b01;
    localparam logic [1:0] c_m2r_pc     = 2'b10;

    localparam logic [1:0] c_srcb_b       = 2'b00;
    localparam logic [1:0] c_srcb_four    = 2'b01;
    localparam logic [1:0] c_srcb_imm     = 2'b10;
    localparam logic [1:0] c_srcb_imm_sh2 = 2'b11;

    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;
    localparam logic [1:0] c_pcsrc_reg    = 2'b11;

    // jr is included: it is a legal R-type even though it bypasses EXEC_R.
    function automatic logic is_rtype_funct_legal(input logic [5:0] funct);
        case (funct)
            c_fn_add, c_fn_sub, c_fn_and, c_fn_or,
            c_fn_slt, c_fn_srl, c_fn_xor, c_fn_jr: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control_if                                                    |
// | Instruction/memory status in, datapath control strobes and selects out.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface multicycle_control_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic       bne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       ext_zero;
    logic       lui;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, bne, iord, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
               alu_src_b, pc_source, alu_op, ext_zero, lui, illegal, state
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, bne, iord, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
               alu_src_b, pc_source, alu_op, ext_zero, lui, illegal, state
    );

endinterface
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_decode                                                               |
// | Combinational ALU operation and immediate-mode decode from opcode/funct. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_decode
    import multicycle_control_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       ext_zero,
    output logic       lui
);

    always_comb begin
        alu_op   = c_alu_add;
        ext_zero = 1'b0;
        lui      = 1'b0;
        if (opcode == c_op_rtype) begin
            case (funct)
                c_fn_sub: alu_op = c_alu_sub;
                c_fn_and: alu_op = c_alu_and;
                c_fn_or:  alu_op = c_alu_or;
                c_fn_xor: alu_op = c_alu_xor;
                c_fn_slt: alu_op = c_alu_slt;
                c_fn_srl: alu_op = c_alu_srl;
                default:  alu_op = c_alu_add;
            endcase
        end else begin
            case (opcode)
                c_op_andi: begin alu_op = c_alu_and; ext_zero = 1'b1; end
                c_op_ori:  begin alu_op = c_alu_or;  ext_zero = 1'b1; end
                c_op_xori: begin alu_op = c_alu_xor; ext_zero = 1'b1; end
                c_op_slti: alu_op = c_alu_slt;
                c_op_lui:  lui = 1'b1;
                default:   alu_op = c_alu_add;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control                                                       |
// | Moore FSM sequencing fetch/decode/execute for a multicycle MIPS subset.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_control_if.master  bus
);

    state_e     state_q;
    state_e     state_d;
    logic [2:0] w_alu_op;
    logic       w_ext_zero;
    logic       w_lui;

    alu_decode u_alu_decode (
        .opcode   (bus.opcode),
        .funct    (bus.funct),
        .alu_op   (w_alu_op),
        .ext_zero (w_ext_zero),
        .lui      (w_lui)
    );

    // Async reset lands in INIT, where every output decodes to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    assign bus.state = state_q;

    always_comb begin
        state_d           = state_q;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.bne           = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = c_dst_rt;
        bus.mem_to_reg    = c_m2r_aluout;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = c_srcb_b;
        bus.pc_source     = c_pcsrc_alu;
        bus.alu_op        = c_alu_and;
        bus.ext_zero      = 1'b0;
        bus.lui           = 1'b0;
        bus.illegal       = 1'b0;

        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = c_srcb_four;
                bus.alu_op    = c_alu_add;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = c_srcb_imm_sh2;
                bus.alu_op    = c_alu_add;
                case (bus.opcode)
                    c_op_lw, c_op_sw: state_d = S_MEM_ADDR;
                    c_op_rtype: begin
                        if (bus.funct == c_fn_jr)
                            state_d = S_JR;
                        else if (is_rtype_funct_legal(bus.funct))
                            state_d = S_EXEC_R;
                        else begin
                            bus.illegal = 1'b1;
                            state_d     = S_FETCH;
                        end
                    end
                    c_op_addi, c_op_andi, c_op_ori,
                    c_op_xori, c_op_slti, c_op_lui: state_d = S_EXEC_I;
                    c_op_beq, c_op_bne:             state_d = S_BRANCH;
                    c_op_j:                         state_d = S_JUMP;
                    c_op_jal:                       state_d = S_JAL;
                    default: begin
                        bus.illegal = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = c_srcb_imm;
                bus.alu_op    = c_alu_add;
                state_d       = (bus.opcode == c_op_lw) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = c_m2r_mdr;
                state_d        = S_FETCH;
            end
            S_MEM_WRITE: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = w_alu_op;
                state_d       = S_R_WB;
            end
            S_R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = c_dst_rd;
                state_d       = S_FETCH;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = c_srcb_imm;
                bus.alu_op    = w_alu_op;
                bus.ext_zero  = w_ext_zero;
                bus.lui       = w_lui;
                state_d       = S_I_WB;
            end
            // Immediate-mode flags stay up so the writeback sees the same operand.
            S_I_WB: begin
                bus.reg_write = 1'b1;
                bus.ext_zero  = w_ext_zero;
                bus.lui       = w_lui;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = c_alu_sub;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = c_pcsrc_aluout;
                bus.bne           = (bus.opcode == c_op_bne);
                state_d           = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = c_pcsrc_jump;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = c_pcsrc_jump;
                bus.reg_write  = 1'b1;
                bus.reg_dst    = c_dst_ra;
                bus.mem_to_reg = c_m2r_pc;
                state_d        = S_FETCH;
            end
            S_JR: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = c_pcsrc_reg;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_control                                                    |
// | Scoreboard bench: per-cycle expected state/controls queued and compared. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       bne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       ext_zero;
        logic       lui;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic [5:0] op;
        logic [5:0] fn;
        ctrl_t      ctrl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23, 6'h2b, 6'h02, 6'h03, 6'h04, 6'h05,
            6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f: return 1'b1;
            6'h00: return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h02, 6'h26, 6'h08};
            default: return 1'b0;
        endcase
    endfunction

    // Expected controls for one cycle, straight from the state output table.
    function automatic ctrl_t ref_ctrl(input logic [3:0] st, input logic [5:0] op,
                                       input logic [5:0] fn, input logic mr);
        ctrl_t c;
        c = '0;
        case (st)
            4'd1: begin c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_op = 3'b010;
                        c.ir_write = mr; c.pc_write = mr; end
            4'd2: begin c.alu_src_b = 2'b11; c.alu_op = 3'b010; c.illegal = !legal(op, fn); end
            4'd3: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 3'b010; end
            4'd4: begin c.mem_read = 1; c.iord = 1; end
            4'd5: begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
            4'd6: begin c.mem_write = 1; c.iord = 1; end
            4'd7: begin
                c.alu_src_a = 1;
                case (fn)
                    6'h20: c.alu_op = 3'b010;  6'h22: c.alu_op = 3'b110;
                    6'h24: c.alu_op = 3'b000;  6'h25: c.alu_op = 3'b001;
                    6'h2a: c.alu_op = 3'b111;  6'h02: c.alu_op = 3'b101;
                    6'h26: c.alu_op = 3'b011;  default: c.alu_op = 3'bxxx;
                endcase
            end
            4'd8: begin c.reg_write = 1; c.reg_dst = 2'b01; end
            4'd9, 4'd10: begin
                c.ext_zero = (op == 6'h0c) || (op == 6'h0d) || (op == 6'h0e);
                c.lui      = (op == 6'h0f);
                if (st == 4'd10) c.reg_write = 1;
                else begin
                    c.alu_src_a = 1; c.alu_src_b = 2'b10;
                    case (op)
                        6'h0c: c.alu_op = 3'b000;  6'h0d: c.alu_op = 3'b001;
                        6'h0e: c.alu_op = 3'b011;  6'h0a: c.alu_op = 3'b111;
                        default: c.alu_op = 3'b010;
                    endcase
                end
            end
            4'd11: begin c.alu_src_a = 1; c.alu_op = 3'b110; c.pc_write_cond = 1;
                         c.pc_source = 2'b01; c.bne = (op == 6'h05); end
            4'd12: begin c.pc_write = 1; c.pc_source = 2'b10; end
            4'd13: begin c.pc_write = 1; c.pc_source = 2'b10; c.reg_write = 1;
                         c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; end
            4'd14: begin c.pc_write = 1; c.pc_source = 2'b11; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctrl_t obs_ctrl();
        ctrl_t c;
        c.pc_write = bus.pc_write;       c.pc_write_cond = bus.pc_write_cond;
        c.bne = bus.bne;                 c.iord = bus.iord;
        c.mem_read = bus.mem_read;       c.mem_write = bus.mem_write;
        c.ir_write = bus.ir_write;       c.reg_write = bus.reg_write;
        c.reg_dst = bus.reg_dst;         c.mem_to_reg = bus.mem_to_reg;
        c.alu_src_a = bus.alu_src_a;     c.alu_src_b = bus.alu_src_b;
        c.pc_source = bus.pc_source;     c.alu_op = bus.alu_op;
        c.ext_zero = bus.ext_zero;       c.lui = bus.lui;
        c.illegal = bus.illegal;
        return c;
    endfunction

    task automatic push(input logic [3:0] st, input logic mr, input logic [5:0] op, input logic [5:0] fn);
        exp_t e;
        e.st = st; e.mr = mr; e.op = op; e.fn = fn;
        e.ctrl = ref_ctrl(st, op, fn, mr);
        sb.push_back(e);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Queue the full expected state trace of one instruction.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm);
        for (int i = 0; i < wf; i++) push(4'd1, 1'b0, op, fn);
        push(4'd1, 1'b1, op, fn);
        push(4'd2, rnd(), op, fn);
        if (legal(op, fn)) begin
            case (op)
                6'h23: begin
                    push(4'd3, rnd(), op, fn);
                    for (int i = 0; i < wm; i++) push(4'd4, 1'b0, op, fn);
                    push(4'd4, 1'b1, op, fn);
                    push(4'd5, rnd(), op, fn);
                end
                6'h2b: begin
                    push(4'd3, rnd(), op, fn);
                    for (int i = 0; i < wm; i++) push(4'd6, 1'b0, op, fn);
                    push(4'd6, 1'b1, op, fn);
                end
                6'h00: begin
                    if (fn == 6'h08) push(4'd14, rnd(), op, fn);
                    else begin push(4'd7, rnd(), op, fn); push(4'd8, rnd(), op, fn); end
                end
                6'h04, 6'h05: push(4'd11, rnd(), op, fn);
                6'h02:        push(4'd12, rnd(), op, fn);
                6'h03:        push(4'd13, rnd(), op, fn);
                default: begin push(4'd9, rnd(), op, fn); push(4'd10, rnd(), op, fn); end
            endcase
        end
    endtask

    task automatic drain(input string name);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            bus.mem_ready = e.mr;
            bus.opcode    = e.op;
            bus.funct     = e.fn;
            #1;
            check({name, "_state"}, 32'(bus.state), 32'(e.st));
            check({name, "_ctrl"}, 32'(obs_ctrl()), 32'(e.ctrl));
        end
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm);
        build(op, fn, wf, wm);
        drain(name);
    endtask

    logic [5:0] ops [22] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                             6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0f,
                             6'h04, 6'h05, 6'h02, 6'h03, 6'h2b, 6'h23, 6'h3f, 6'h00};
    logic [5:0] fns [22] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h02, 6'h26, 6'h08,
                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3f};

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", 32'(bus.state), 32'd0);
        check("reset_ctrl", 32'(obs_ctrl()), 32'd0);

        // Release between edges: INIT is still visible until the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_state", 32'(bus.state), 32'd0);

        run_instr("lw_wait", 6'h23, 6'h00, 2, 2);

        for (int i = 0; i < 22; i++)
            run_instr($sformatf("op%0h_fn%0h", ops[i], fns[i]), ops[i], fns[i],
                      $urandom_range(0, 2), $urandom_range(0, 2));

        run_instr("sw_wait", 6'h2b, 6'h00, 1, 3);

        // Enter MEM_WRITE with memory stalled, then pull reset between edges.
        push(4'd1, 1'b1, 6'h2b, 6'h00);
        push(4'd2, 1'b1, 6'h2b, 6'h00);
        push(4'd3, 1'b1, 6'h2b, 6'h00);
        push(4'd6, 1'b0, 6'h2b, 6'h00);
        drain("sw_pre_rst");
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_write", 32'(bus.mem_write), 32'd0);
        check("rst_mid_state", 32'(bus.state), 32'd0);
        check("rst_mid_ctrl", 32'(obs_ctrl()), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_state", 32'(bus.state), 32'd0);
        run_instr("add_after_rst", 6'h00, 6'h20, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset, decided exactly so: clk input 1 (rising edge); rst_n input 1 (asynchronous, active-low).
REQ-002 SHALL provide these inputs:
- opcode in 6: instruction register bits [31:26], stable after FETCH.
- funct in 6: instruction register bits [5:0].
- mem_ready in 1: memory completes the current access this cycle.
REQ-003 SHALL provide these write and memory outputs:
- pc_write out 1: unconditional PC load.
- pc_write_cond out 1: PC load when branch condition met.
- bne out 1: branch condition is not-zero; 0 means zero.
- iord out 1: memory address select, 0=PC, 1=ALUOut.
- mem_read out 1.
- mem_write out 1.
- ir_write out 1.
- reg_write out 1.
REQ-004 SHALL provide these mux-select outputs:
- reg_dst out 2: 00=rt, 01=rd, 10=$31.
- mem_to_reg out 2: 00=ALUOut, 01=MDR, 10=PC.
- alu_src_a out 1: 0=PC, 1=A.
- alu_src_b out 2: 00=B, 01=4, 10=ext imm, 11=ext imm<<2.
- pc_source out 2: 00=ALU, 01=ALUOut, 10=jump target, 11=A.
REQ-005 SHALL provide these ALU and status outputs:
- alu_op out 3: and 000, or 001, add 010, xor 011, srl 101, sub 110, slt 111.
- ext_zero out 1: zero-extend imm (andi/ori/xori).
- lui out 1: load upper immediate.
- illegal out 1: one-cycle pulse on unsupported instruction.
- state out 4: current state encoding.

Function
REQ-006 SHALL be a Moore FSM; outputs decode from state (plus opcode/funct/mem_ready where listed); every output not listed for a state SHALL be 0.
REQ-007 SHALL use these state encodings: INIT 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXEC_R 7, R_WB 8, EXEC_I 9, I_WB 10, BRANCH 11, JUMP 12, JAL 13, JR 14; 15 is unreachable and SHALL go to FETCH.
REQ-008 INIT: all outputs 0; next FETCH.
REQ-009 FETCH: mem_read=1, alu_src_b=01, alu_op=add, ir_write=pc_write=mem_ready; hold while mem_ready=0, else DECODE.
REQ-010 DECODE: alu_src_b=11, alu_op=add (branch target). Next state:
- lw/sw: MEM_ADDR.
- R-type with funct 08: JR.
- Other supported R-type: EXEC_R.
- addi/andi/ori/xori/slti/lui: EXEC_I.
- beq/bne: BRANCH.
- j: JUMP.
- jal: JAL.
- Else: illegal=1, next FETCH.
REQ-011 Supported R-type funct values SHALL be 20, 22, 24, 25, 2a, 02, 26, 08; any other funct SHALL be illegal.
REQ-012 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=add; next MEM_READ for lw, MEM_WRITE for sw.
REQ-013 MEM_READ: mem_read=1, iord=1; hold until mem_ready, then MEM_WB.
REQ-014 MEM_WB: reg_write=1, mem_to_reg=01; next FETCH.
REQ-015 MEM_WRITE: mem_write=1, iord=1; hold until mem_ready, then FETCH.
REQ-016 EXEC_R: alu_src_a=1, alu_op from funct; next R_WB.
REQ-017 R_WB: reg_write=1, reg_dst=01; next FETCH.
REQ-018 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op from opcode (addi add, andi and, ori or, xori xor, slti slt, lui add); ext_zero and lui per opcode; next I_WB.
REQ-019 I_WB: reg_write=1, ext_zero and lui held; next FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_op=sub, pc_write_cond=1, pc_source=01, bne=(opcode==05); next FETCH.
REQ-021 JUMP: pc_write=1, pc_source=10. JAL: same, plus reg_write=1, reg_dst=10, mem_to_reg=10. JR: pc_write=1, pc_source=11. All three next FETCH.
REQ-022 Instruction latencies SHALL be, with zero memory wait: lw 5 cycles; sw/R/I 4; branch/jump/jal/jr 3. Each mem_ready=0 cycle SHALL add one cycle.

Reset
REQ-023 rst_n=0 SHALL force state=INIT immediately, independent of clk, so all outputs are 0, including mid-access (mem_write SHALL drop asynchronously).
REQ-024 The first rising clk after rst_n deasserts SHALL move INIT to FETCH.

Structure
REQ-025 A shared package SHALL hold the state encodings, opcode/funct constants, alu_op codes and the reg_dst/mem_to_reg/alu_src_b/pc_source select codes.
REQ-026 alu_op decode SHALL be one sub-module, alu_decode: combinational opcode/funct in, alu_op/ext_zero/lui out.

Verification
REQ-027 Reset then lw (op 23) with mem_ready low 2 cycles in FETCH and MEM_READ -> states 0,1,1,1,2,3,4,4,4,5,1; reg_write only in MEM_WB.
REQ-028 Scenario R-type: add (op 00, funct 20), mem_ready=1 -> states 1,2,7,8,1, alu_op=010 in EXEC_R, reg_dst=01 in R_WB.
REQ-029 Scenario branch: bne (op 05) -> BRANCH shows pc_write_cond=1, bne=1, alu_op=110, pc_source=01, 3 cycles total.
REQ-030 Scenario jal: jal (op 03) -> JAL shows pc_write=1, reg_dst=10, mem_to_reg=10, reg_write=1.
REQ-031 Scenario illegal: op 3f, or op 00 with funct 3f -> illegal=1 for exactly one DECODE cycle, then FETCH, with no write strobes.
REQ-032 Scenario reset mid-write: rst_n low mid-cycle during MEM_WRITE -> mem_write=0 and state=0 before next clk edge.
